// File: rtl/reg_access_arbiter.sv
// rtl/reg_access_arbiter.sv - round-robin arbiter sharing one register-map access port
// Each grant issues exactly one access and answers with a one-cycle ack carrying read data.
module reg_access_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           ack_rdata,
  output logic [ADDR_W-1:0]           reg_addr,
  output logic [DATA_W-1:0]           reg_wdata,
  output logic                        reg_wr_en,
  input  logic [DATA_W-1:0]           reg_rdata,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [1:0] LAST_CNT = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [IDX_W-1:0]   grant, grant_d;
  logic [IDX_W-1:0]   sel, cand;
  logic               found;
  logic               we_q, we_d;
  logic [1:0]         cnt, cnt_d;
  logic [NUM_REQ-1:0] ack_d;
  logic [DATA_W-1:0]  ack_rdata_d;
  logic [ADDR_W-1:0]  reg_addr_d;
  logic [DATA_W-1:0]  reg_wdata_d;
  logic               reg_wr_en_d;
  logic               busy_d;

  // Scan downward so the requester closest above the pointer is the last (winning) match.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    grant_d     = grant;
    we_d        = we_q;
    cnt_d       = cnt;
    ack_d       = '0;
    ack_rdata_d = '0;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    reg_wr_en_d = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_d     = sel;
          we_d        = req_we[sel];
          reg_addr_d  = req_addr[sel*ADDR_W +: ADDR_W];
          reg_wdata_d = req_wdata[sel*DATA_W +: DATA_W];
          reg_wr_en_d = req_we[sel];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = 2'd0;
        if (we_q) begin
          ack_d[grant] = 1'b1;
          state_d      = ACK;
        end else if (RD_LATENCY == 0) begin
          ack_d[grant] = 1'b1;
          ack_rdata_d  = reg_rdata;
          state_d      = ACK;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAST_CNT) begin
          ack_d[grant] = 1'b1;
          ack_rdata_d  = reg_rdata;
          state_d      = ACK;
        end else begin
          cnt_d = cnt + 2'd1;
        end
      end
      ACK: begin
        ptr_d   = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Every output is a flop loaded with the value it must show in the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      we_q      <= 1'b0;
      cnt       <= 2'd0;
      ack       <= '0;
      ack_rdata <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      grant     <= grant_d;
      we_q      <= we_d;
      cnt       <= cnt_d;
      ack       <= ack_d;
      ack_rdata <= ack_rdata_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_wr_en <= reg_wr_en_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb/tb_reg_access_arbiter.sv - randomized scoreboard bench for reg_access_arbiter
// Two instances: NUM_REQ=2/RD_LATENCY=0 and NUM_REQ=3/RD_LATENCY=2.
module tb_reg_access_arbiter;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } iss_t;

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] rdata;
  } ack_t;

  task automatic check_eq(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] scr(input logic [7:0] a);
    return a * 8'h3B + 8'h11;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int NR  = 2 + g;
    localparam int LAT = 2 * g;

    logic              rst = 1'b1;
    logic [NR-1:0]     req, req_we, ack;
    logic [NR*8-1:0]   req_addr, req_wdata;
    logic [7:0]        ack_rdata, reg_addr, reg_wdata, reg_rdata, rd_a;
    logic              reg_wr_en, busy;
    bit                done = 1'b0;

    reg_access_arbiter #(.NUM_REQ(NR), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack), .ack_rdata(ack_rdata), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rdata(reg_rdata), .busy(busy)
    );

    // Register map stand-in: read data appears LAT cycles after the address.
    bit   [7:0] mem [256];
    logic [7:0] ahist [4];
    always @(posedge clk) begin
      if (reg_wr_en) mem[reg_addr] <= reg_wdata ^ scr(reg_addr);
      ahist[0] <= reg_addr;
      for (int k = 1; k < 4; k++) ahist[k] <= ahist[k-1];
    end
    assign rd_a      = (LAT == 0) ? reg_addr : ahist[(LAT == 0) ? 0 : LAT - 1];
    assign reg_rdata = mem[rd_a] ^ scr(rd_a);

    iss_t       iss_q[$];
    ack_t       ack_q[$];
    bit [7:0]   mm [256];
    int         cool [NR];
    int         ptr_m = 0, free_m = 0, bfrom = 1, buntil = 0;
    logic [7:0] cur_addr = 8'h00;

    task automatic model_grant();
      int idx;
      int ac;
      iss_t ie;
      ack_t ae;
      idx = -1;
      if (cyc < free_m || req == '0) return;
      for (int k = 0; k < NR; k++)
        if (idx < 0 && req[(ptr_m + k) % NR]) idx = (ptr_m + k) % NR;
      ie.cyc   = cyc + 1;
      ie.we    = req_we[idx];
      ie.addr  = req_addr[idx*8 +: 8];
      ie.wdata = req_wdata[idx*8 +: 8];
      iss_q.push_back(ie);
      ac       = cyc + 2 + (ie.we ? 0 : LAT);
      ae.cyc   = ac;
      ae.idx   = idx;
      ae.rdata = ie.we ? 8'h00 : mm[ie.addr];
      ack_q.push_back(ae);
      if (ie.we) mm[ie.addr] = ie.wdata;
      free_m   = ac + 1;
      ptr_m    = (idx + 1) % NR;
      bfrom    = cyc + 1;
      buntil   = ac;
      cur_addr = ie.addr;
    endtask

    task automatic step(input bit allow_new);
      for (int i = 0; i < NR; i++) begin
        if (req[i] && ack[i]) begin
          req[i]  = 1'b0;
          cool[i] = $urandom_range(0, 3);
        end else if (req[i] && $urandom_range(0, 40) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if (cool[i] > 0) cool[i]--;
          else if (allow_new && $urandom_range(0, 2) == 0) begin
            req[i]            = 1'b1;
            req_we[i]         = 1'($urandom_range(0, 1));
            req_addr[i*8 +: 8]  = 8'($urandom_range(0, 15));
            req_wdata[i*8 +: 8] = 8'($urandom);
          end
        end
      end
      model_grant();
    endtask

    task automatic check_zero(input string tag);
      check_eq({tag, "_ack"}, ack, 0);
      check_eq({tag, "_ack_rdata"}, ack_rdata, 0);
      check_eq({tag, "_reg_addr"}, reg_addr, 0);
      check_eq({tag, "_reg_wdata"}, reg_wdata, 0);
      check_eq({tag, "_reg_wr_en"}, reg_wr_en, 0);
      check_eq({tag, "_busy"}, busy, 0);
    endtask

    initial begin : stim
      bit [7:0] saved;
      for (int a = 0; a < 256; a++) mm[a] = scr(8'(a));
      for (int i = 0; i < NR; i++) cool[i] = 0;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      @(negedge clk);
      check_zero("reset");
      @(negedge clk);
      rst    = 1'b0;
      free_m = cyc;
      repeat (600) begin @(negedge clk); step(1'b1); end
      repeat (40)  begin @(negedge clk); step(1'b0); end

      // Abort a write in its ISSUE cycle; the register must not be written.
      saved = mm[3];
      @(negedge clk);
      req = '0;
      req[0] = 1'b1; req_we[0] = 1'b1; req_addr[7:0] = 8'h03; req_wdata[7:0] = 8'($urandom);
      model_grant();
      @(negedge clk);
      #3 rst = 1'b1;
      #1 check_zero("abort");
      req = '0;
      iss_q.delete();
      ack_q.delete();
      mm[3] = saved;
      bfrom = 1; buntil = 0;
      @(negedge clk);
      @(negedge clk);
      rst    = 1'b0;
      free_m = cyc;
      ptr_m  = 0;
      req[1:0] = 2'b11;
      for (int i = 0; i < 2; i++) begin
        req_we[i]           = 1'($urandom_range(0, 1));
        req_addr[i*8 +: 8]  = 8'($urandom_range(0, 15));
        req_wdata[i*8 +: 8] = 8'($urandom);
      end
      model_grant();
      repeat (300) begin @(negedge clk); step(1'b1); end
      repeat (40)  begin @(negedge clk); step(1'b0); end
      check_eq("drain_ack_q", ack_q.size(), 0);
      check_eq("drain_iss_q", iss_q.size(), 0);
      done = 1'b1;
    end

    initial begin : mon
      ack_t          ae;
      iss_t          ie;
      logic [NR-1:0] oh;
      bit            exp_busy;
      while (!done) begin
        @(negedge clk);
        if (rst) continue;
        if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
          ae = ack_q.pop_front();
          oh = '0;
          oh[ae.idx] = 1'b1;
          check_eq("ack_grant", ack, oh);
          check_eq("ack_rdata", ack_rdata, ae.rdata);
        end else begin
          check_eq("ack_quiet", ack, 0);
        end
        if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
          ie = iss_q.pop_front();
          check_eq("issue_wr_en", reg_wr_en, ie.we);
          check_eq("issue_addr", reg_addr, ie.addr);
          if (ie.we) check_eq("issue_wdata", reg_wdata, ie.wdata);
        end else begin
          check_eq("wr_en_quiet", reg_wr_en, 0);
        end
        exp_busy = (cyc >= bfrom && cyc <= buntil);
        check_eq("busy", busy, exp_busy);
        if (exp_busy) check_eq("addr_stable", reg_addr, cur_addr);
      end
    end
  end

  initial begin : top
    bit fin;
    fin = 1'b0;
    for (int k = 0; k < 6000 && !fin; k++) begin
      @(posedge clk);
      fin = inst[0].done && inst[1].done;
    end
    check_eq("run_complete", fin, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares the single register-map access port (addr / wdata / write strobe / rdata) between NUM_REQ requesters, e.g. the synchronized I2C-slave write path and on-chip sequencers.
- Each requester runs a req/ack handshake. The arbiter grants round-robin, issues exactly one register access, and returns read data with a one-cycle ack.
- Sits in the clk domain between the requesters and reg_map.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, register address width.
- DATA_W, 8, register data width.
- RD_LATENCY, 0, clk cycles from reg_addr valid to reg_rdata valid (0..3).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  NUM_REQ  per-requester request level.
- req_we  input  NUM_REQ  1 = write, 0 = read; held with req.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing.
- ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- ack_rdata  output  DATA_W  read data, valid only while ack is high.
- reg_addr  output  ADDR_W  address to reg_map.
- reg_wdata  output  DATA_W  write data to reg_map.
- reg_wr_en  output  1  single-cycle write strobe to reg_map.
- reg_rdata  input  DATA_W  read data from reg_map.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE; ack=0, ack_rdata=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, busy=0; round-robin pointer=0; grant register=0; wait counter=0. Reset mid-transaction aborts the access immediately, with no ack and reg_wr_en low.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from the pointer with wrap-around.
  - Latch grant index, we, addr, wdata; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - reg_addr and reg_wdata drive the latched values.
  - reg_wr_en=1 only if we=1.
  - Write → ACK.
  - Read with RD_LATENCY=0: capture reg_rdata at the end of this cycle → ACK.
  - Read with RD_LATENCY>0: → WAIT.
- WAIT:
  - Counter runs RD_LATENCY cycles; capture reg_rdata at the end of the last one → ACK.
  - reg_addr stays stable throughout.
- ACK (1 cycle):
  - ack[grant]=1. ack_rdata = captured data on a read, 0 on a write.
  - Pointer = (grant+1) mod NUM_REQ → IDLE.
- reg_addr and reg_wdata hold their last issued values outside ISSUE/WAIT and never glitch. reg_wr_en is low in every state other than ISSUE.
- Latency:
  - req seen high in IDLE cycle t → ISSUE at t+1.
  - Write ack at t+2.
  - Read ack at t+2+RD_LATENCY.
  - Minimum back-to-back spacing is 3 cycles per transaction (IDLE, ISSUE, ACK).
- Requester rules:
  - Hold req, we, addr, wdata stable until ack.
  - Drop req on the clock edge that samples ack=1. A req still high in the following IDLE cycle is treated as a new transaction.
- Payload is latched at grant, so req dropping or payload changing during ISSUE/WAIT does not affect the access. The transaction completes and ack still pulses.
- Simultaneous requests: exactly one grant; the other requests remain pending and are served in round-robin order.
- No requester is starved: with all req high, grants rotate 0,1,…,NUM_REQ-1,0.

Test Plan:
- Single write, req[0], addr=0x02, wdata=0xA5, NUM_REQ=2 → reg_wr_en high exactly 1 cycle with reg_addr=0x02, reg_wdata=0xA5; ack[0] 2 cycles after req sampled; ack_rdata=0x00.
- Read, req[1], addr=0x02, reg_map returning 0xA5, RD_LATENCY=0 then 2 → ack[1] at t+2 then t+4; ack_rdata=0xA5; reg_wr_en never high.
- req[0] and req[1] asserted together and held for 4 transactions → grant order 0,1,0,1; no overlapping ack bits; reg_wr_en count=4.
- req[1] dropped during WAIT (RD_LATENCY=2) → read still completes; ack[1] pulses once; next IDLE grants nothing.
- rst asserted during ISSUE of a write to 0x03 → reg_wr_en low asynchronously; no ack; all outputs 0; first grant after release goes to requester 0 when both request.
